// File: rtl/axi_pkt_gen.sv
// AXI-stream burst generator: emits num_pkts packets of pkt_len words, with a configurable idle gap.
// One-cycle start latency, one word per cycle when o_tready is held; outputs stay stable under backpressure.
module axi_pkt_gen #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic [15:0]      pkt_len,
  input  logic [15:0]      num_pkts,
  input  logic [7:0]       gap,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pkt_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]  state;
  logic [15:0] len_q;
  logic [15:0] npkts_q;
  logic [7:0]  gap_q;
  logic [7:0]  gap_cnt;
  logic [15:0] word_idx;
  logic [15:0] pkt_num;
  logic        xfer;
  logic        last_word;
  logic        last_pkt;

  assign xfer      = o_tvalid & o_tready;
  assign last_word = (word_idx == len_q - 16'd1);
  assign last_pkt  = (pkt_num == npkts_q - 16'd1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state     <= IDLE;
      len_q     <= '0;
      npkts_q   <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      word_idx  <= '0;
      pkt_num   <= '0;
      pkt_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q     <= pkt_len;
            npkts_q   <= num_pkts;
            gap_q     <= gap;
            word_idx  <= '0;
            pkt_num   <= '0;
            pkt_count <= '0;
            state     <= (pkt_len == 16'd0 || num_pkts == 16'd0) ? FIN : DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            if (last_word) begin
              word_idx  <= '0;
              pkt_num   <= pkt_num + 16'd1;
              pkt_count <= pkt_count + 16'd1;
              if (last_pkt) begin
                state <= FIN;
              end else if (gap_q != 8'd0) begin
                // counts down to zero so GAP lasts exactly gap_q cycles
                state   <= GAP;
                gap_cnt <= gap_q - 8'd1;
              end
            end else begin
              word_idx <= word_idx + 16'd1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) state <= DATA;
          else                 gap_cnt <= gap_cnt - 8'd1;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state, so they cannot change while stalled.
  assign o_tvalid = (state == DATA);
  assign o_tlast  = o_tvalid & last_word;
  assign busy     = (state != IDLE);
  assign done     = (state == FIN);

  always_comb begin
    o_tdata = '0;
    if (o_tvalid) o_tdata[31:0] = {pkt_num, word_idx};
  end

endmodule

// File: tb/tb_axi_pkt_gen.sv
// Scoreboard bench for axi_pkt_gen: expected words queued at start, checked on each handshake.
module tb_axi_pkt_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pkt_len = '0;
  logic [15:0] num_pkts = '0;
  logic [7:0]  gap = '0;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic        busy;
  logic        done;
  logic [15:0] pkt_count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [32:0] sb[$];

  bit          prev_stall = 1'b0;
  bit          prev_rst   = 1'b0;
  logic [31:0] prev_dat   = '0;
  logic        prev_last  = 1'b0;

  axi_pkt_gen #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start),
    .pkt_len(pkt_len), .num_pkts(num_pkts), .gap(gap),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .busy(busy), .done(done), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Handshake monitor: pops the scoreboard and checks hold-stability under stall.
  always @(negedge clk) begin
    logic [32:0] e;
    if (prev_stall && !prev_rst) begin
      chk("stall_vld", o_tvalid, 1);
      chk("stall_dat", o_tdata, prev_dat);
      chk("stall_last", o_tlast, prev_last);
    end
    if (o_tvalid === 1'b1 && o_tready && !(reset || clear)) begin
      chk("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_data", o_tdata, e[31:0]);
        chk("sb_last", o_tlast, e[32]);
      end
    end
    prev_stall = (o_tvalid === 1'b1) && !o_tready;
    prev_rst   = reset || clear;
    prev_dat   = o_tdata;
    prev_last  = o_tlast;
  end

  task automatic run_burst(input int len, input int n, input int g, input bit rnd, input int inj_k,
                           output int vcnt, output int first_v, output int done_k,
                           output int busy_cnt, output int gmin, output int gmax, output int gruns);
    int  budget;
    int  run;
    bit  seen_v;
    int  exp_cnt;
    for (int p = 0; p < n; p++)
      for (int w = 0; w < len; w++)
        sb.push_back({(w == len - 1), p[15:0], w[15:0]});
    exp_cnt  = (len == 0 || n == 0) ? 0 : n;
    pkt_len  = len[15:0];
    num_pkts = n[15:0];
    gap      = g[7:0];
    start    = 1'b1;
    o_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vcnt = 0; first_v = -1; done_k = -1; busy_cnt = 0;
    gmin = 100000; gmax = -1; gruns = 0; run = 0; seen_v = 0;
    budget = len * n * 4 + n * (g + 2) + 20;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (o_tvalid) begin
        vcnt++;
        if (first_v < 0) first_v = k;
        if (seen_v && run > 0) begin
          gruns++;
          if (run < gmin) gmin = run;
          if (run > gmax) gmax = run;
        end
        run = 0;
        seen_v = 1;
      end else if (seen_v) begin
        run++;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_k = k;
        break;
      end
      @(posedge clk); #1;
      o_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k == inj_k) begin
        start = 1'b1; pkt_len = 16'd9; num_pkts = 16'd1; gap = 8'd0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("burst_done_seen", done_k >= 0, 1);
    chk("burst_pkt_count", pkt_count, exp_cnt);
    chk("burst_sb_drained", sb.size(), 0);
    @(posedge clk); #1;
    o_tready = 1'b1;
    @(negedge clk);
    chk("burst_done_one_cycle", done, 0);
    chk("burst_idle_busy", busy, 0);
    sb.delete();
  endtask

  initial begin
    int vc, fv, dk, bc, gmn, gmx, gr;
    bit found;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", o_tvalid, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_vld", o_tvalid, 0);
    chk("idle_last", o_tlast, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_cnt", pkt_count, 0);
    chk("idle_dat", o_tdata, 0);

    // Back-to-back: two 4-word packets with no bubble
    @(posedge clk); #1;
    run_burst(4, 2, 0, 0, -1, vc, fv, dk, bc, gmn, gmx, gr);
    chk("b2b_vcnt", vc, 8);
    chk("b2b_first", fv, 0);
    chk("b2b_done_k", dk, 8);
    chk("b2b_no_gap", gr, 0);

    // Inter-packet gap of 5 idle cycles
    @(posedge clk); #1;
    run_burst(3, 3, 5, 0, -1, vc, fv, dk, bc, gmn, gmx, gr);
    chk("gap_vcnt", vc, 9);
    chk("gap_runs", gr, 2);
    chk("gap_min", gmn, 5);
    chk("gap_max", gmx, 5);
    chk("gap_done_k", dk, 19);

    // Random backpressure
    @(posedge clk); #1;
    run_burst(7, 4, 2, 1, -1, vc, fv, dk, bc, gmn, gmx, gr);
    chk("rnd_vcnt_min", vc >= 28, 1);

    // Zero-length packets: nothing emitted, FIN only
    @(posedge clk); #1;
    run_burst(0, 5, 0, 0, -1, vc, fv, dk, bc, gmn, gmx, gr);
    chk("zlen_vcnt", vc, 0);
    chk("zlen_done_k", dk, 0);
    chk("zlen_busy", bc, 1);

    @(posedge clk); #1;
    run_burst(4, 0, 0, 0, -1, vc, fv, dk, bc, gmn, gmx, gr);
    chk("znum_vcnt", vc, 0);
    chk("znum_done_k", dk, 0);

    // Clear while word 2 of packet 1 is stalled
    @(posedge clk); #1;
    for (int p = 0; p < 3; p++)
      for (int w = 0; w < 4; w++)
        sb.push_back({(w == 3), p[15:0], w[15:0]});
    pkt_len = 16'd4; num_pkts = 16'd3; gap = 8'd0; o_tready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_tvalid && o_tdata == 32'h0001_0001) begin
        found = 1;
        break;
      end
    end
    chk("clr_reached", found, 1);
    @(posedge clk); #1;
    o_tready = 1'b0;
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("clr_word2", o_tdata, 32'h0001_0002);
    chk("clr_cnt_before", pkt_count, 1);
    @(posedge clk); #1;
    clear = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("clr_vld", o_tvalid, 0);
    chk("clr_last", o_tlast, 0);
    chk("clr_busy", busy, 0);
    chk("clr_cnt", pkt_count, 0);
    chk("clr_dat", o_tdata, 0);
    sb.delete();
    @(posedge clk); #1;
    o_tready = 1'b1;
    run_burst(2, 2, 0, 0, -1, vc, fv, dk, bc, gmn, gmx, gr);
    chk("post_clr_vcnt", vc, 4);

    // Start and config change mid-burst are ignored
    @(posedge clk); #1;
    run_burst(3, 2, 1, 0, 2, vc, fv, dk, bc, gmn, gmx, gr);
    chk("ign_vcnt", vc, 6);
    chk("ign_done_k", dk, 7);

    // Maximum packet length without counter wrap
    @(posedge clk); #1;
    run_burst(65535, 1, 0, 0, -1, vc, fv, dk, bc, gmn, gmx, gr);
    chk("max_vcnt", vc, 65535);
    chk("max_done_k", dk, 65535);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
